uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_if.sv | 10 +
 rtl/uart_rx_sync_2ff.sv | 25 ++
 rtl/uart_rx.sv | 131 +++++++++++++
 tb/tb_uart_rx.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings and default bit timing.
// The transmitter imports this package as well.
package uart_pkg;
  localparam int COUNT_CYCLES_DEF = 100_000_000 / 9600;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_START    = 3'd1;
  localparam logic [2:0] ST_DATA     = 3'd2;
  localparam logic [2:0] ST_STOP     = 3'd3;
  localparam logic [2:0] ST_CLEAN_UP = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    START    = ST_START,
    DATA     = ST_DATA,
    STOP     = ST_STOP,
    CLEAN_UP = ST_CLEAN_UP
  } uart_state_e;
endpackage

// File: rtl/uart_rx_if.sv
// Parallel side of the UART receiver: received byte, strobes and busy flag.
interface uart_rx_if;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (output data_out, valid, frame_err, busy);
  modport slave  (input  data_out, valid, frame_err, busy);
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs, with a
// parameterised reset value so idle-high lines come out of reset idle.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta_q, sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a qualified start edge,
// byte output with one-cycle valid / frame_err strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int COUNT_CYCLES = COUNT_CYCLES_DEF
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master bus
);
  localparam logic [15:0] HALF_M1 = 16'(COUNT_CYCLES / 2 - 1);
  localparam logic [15:0] BIT_M1  = 16'(COUNT_CYCLES - 1);

  logic rx_s;

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  uart_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    data_out_d  = data_out_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        busy_d    = 1'b0;
        if (!rx_s) begin
          state_d = START;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            // start bit did not survive to mid-bit: treat as a glitch
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d              = '0;
          shreg_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          state_d = CLEAN_UP;
          if (rx_s) begin
            data_out_d = shreg_q;
            valid_d    = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      CLEAN_UP: begin
        // hold here through a break so a held-low line cannot start a frame
        if (rx_s) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: bit-accurate serial driver feeding a byte scoreboard.
module tb_uart_rx;
  localparam int C    = 16;
  localparam int HALF = C / 2;

  logic clk = 1'b0;
  logic rst;
  logic rx;

  uart_rx_if bus();

  uart_rx #(.COUNT_CYCLES(C)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         valid_cnt = 0;
  int         ferr_cnt  = 0;
  int         busy_cyc  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard side: every valid strobe pops one expected byte
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) check("valid_unexpected", 32'(bus.data_out), 32'hFFFF_FFFF);
        else                   check("rx_byte", 32'(bus.data_out), 32'(exp_q.pop_front()));
      end
      if (bus.frame_err) ferr_cnt++;
      if (bus.busy) busy_cyc++;
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // leaves rx at the stop-bit level; caller decides what follows
  task automatic send_byte(input logic [7:0] b, input int period, input logic stop);
    if (stop) begin
      exp_q.push_back(b);
      last_good = b;
    end
    rx = 1'b0;
    repeat (period) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (period) @(negedge clk);
    end
    rx = stop;
    repeat (period) @(negedge clk);
  endtask

  int v0, f0;

  initial begin
    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data_out", 32'(bus.data_out), 32'h0);
    check("rst_valid", 32'(bus.valid), 32'h0);
    check("rst_frame_err", 32'(bus.frame_err), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    rst = 1'b0;
    idle(10);

    // single byte, with exact busy window
    busy_cyc = 0;
    v0 = valid_cnt;
    send_byte(8'hA5, C, 1'b1);
    idle(20);
    check("single_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("single_data_out", 32'(bus.data_out), 32'hA5);
    check("single_busy_cycles", 32'(busy_cyc), 32'(HALF + 9 * C + 1));
    check("single_ferr", 32'(ferr_cnt), 32'd0);

    // back-to-back frames, no idle gap
    v0 = valid_cnt;
    send_byte(8'h00, C, 1'b1);
    send_byte(8'hFF, C, 1'b1);
    send_byte(8'h3C, C, 1'b1);
    idle(20);
    check("b2b_valid_cnt", 32'(valid_cnt - v0), 32'd3);
    check("b2b_data_out", 32'(bus.data_out), 32'h3C);

    // short low glitch on an idle line
    busy_cyc = 0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(30);
    check("glitch_valid", 32'(valid_cnt - v0), 32'd0);
    check("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("glitch_busy_cycles", 32'(busy_cyc), 32'(HALF));
    check("glitch_data_out", 32'(bus.data_out), 32'h3C);

    // stop bit low, then a long break
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_byte(8'h55, C, 1'b0);
    repeat (40) @(negedge clk);
    check("break_ferr_cnt", 32'(ferr_cnt - f0), 32'd1);
    check("break_valid", 32'(valid_cnt - v0), 32'd0);
    check("break_data_out", 32'(bus.data_out), 32'(last_good));
    check("break_busy_held", 32'(bus.busy), 32'd1);
    idle(20);
    check("break_busy_release", 32'(bus.busy), 32'd0);
    check("break_ferr_final", 32'(ferr_cnt - f0), 32'd1);

    // reset in the middle of data bit 4 of 0x81
    v0 = valid_cnt;
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = ((8'h81 >> i) & 8'h01) != 0;
      repeat (C) @(negedge clk);
    end
    rx = 1'b0;
    repeat (C / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_rst_data_out", 32'(bus.data_out), 32'h0);
    check("abort_rst_busy", 32'(bus.busy), 32'h0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    idle(10);
    check("abort_no_valid", 32'(valid_cnt - v0), 32'd0);
    send_byte(8'h42, C, 1'b1);
    idle(20);
    check("after_abort_data", 32'(bus.data_out), 32'h42);

    // transmitter bit-rate skew, both directions
    v0 = valid_cnt;
    send_byte(8'hC3, 15, 1'b1);
    idle(30);
    check("skew15_data", 32'(bus.data_out), 32'hC3);
    send_byte(8'hC3, 17, 1'b1);
    idle(30);
    check("skew17_data", 32'(bus.data_out), 32'hC3);
    check("skew_valid_cnt", 32'(valid_cnt - v0), 32'd2);

    check("total_valid", 32'(valid_cnt), 32'd7);
    check("total_ferr", 32'(ferr_cnt), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
